// File: rtl/imm_encoder.sv
// RV32I immediate encoder: packs an immediate into the scattered fields of a base
// instruction word, range-checks it, and emits it with a sequential word address.
module imm_encoder #(
    parameter int unsigned       ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_src,
    input  logic [31:0]       imm,
    input  logic [31:0]       base_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic              out_err_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    logic [7:0]        err_count_q;

    logic [31:0]       enc_instr_d;
    logic              enc_err_d;
    logic              accept;
    logic [ADDR_W-1:0] addr_cnt_d;
    logic [7:0]        err_count_d;

    // Sign-run checks: the upper bits must all be copies of the top kept bit.
    logic sext_12_ok;
    logic sext_13_ok;
    logic sext_21_ok;

    assign sext_12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign sext_13_ok = (&imm[31:12]) | ~(|imm[31:12]);
    assign sext_21_ok = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_instr_d = base_instr;
        enc_err_d   = 1'b1;
        case (imm_src)
            FMT_I: begin
                enc_instr_d = {imm[11:0], base_instr[19:0]};
                enc_err_d   = ~sext_12_ok;
            end
            FMT_S: begin
                enc_instr_d = {imm[11:5], base_instr[24:12], imm[4:0], base_instr[6:0]};
                enc_err_d   = ~sext_12_ok;
            end
            FMT_B: begin
                enc_instr_d = {imm[12], imm[10:5], base_instr[24:12],
                               imm[4:1], imm[11], base_instr[6:0]};
                enc_err_d   = ~sext_13_ok | imm[0];
            end
            FMT_J: begin
                enc_instr_d = {imm[20], imm[10:1], imm[11], imm[19:12], base_instr[11:0]};
                enc_err_d   = ~sext_21_ok | imm[0];
            end
            FMT_U: begin
                enc_instr_d = {imm[31:12], base_instr[11:0]};
                enc_err_d   = |imm[11:0];
            end
            default: begin
                enc_instr_d = base_instr;
                enc_err_d   = 1'b1;
            end
        endcase
    end

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // clr wins over the increment; an item accepted alongside clr takes BASE_ADDR.
    always_comb begin
        addr_cnt_d  = addr_cnt_q;
        err_count_d = err_count_q;
        if (clr) begin
            addr_cnt_d  = accept ? (BASE_ADDR + ADDR_ONE) : BASE_ADDR;
            err_count_d = (accept && enc_err_d) ? 8'd1 : 8'd0;
        end else if (accept) begin
            addr_cnt_d = addr_cnt_q + ADDR_ONE;
            if (enc_err_d && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
            out_addr_q  <= BASE_ADDR;
            addr_cnt_q  <= BASE_ADDR;
            err_count_q <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_instr_q <= enc_instr_d;
                out_err_q   <= enc_err_d;
                out_addr_q  <= clr ? BASE_ADDR : addr_cnt_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            addr_cnt_q  <= addr_cnt_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign out_addr  = out_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed cases with literal expectations plus a randomized
// run against a bit-map/arithmetic reference model and an extender round-trip check.
module tb_imm_encoder;

    localparam int ADDR_W = 2;
    localparam int BASE   = 0;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        imm_src;
    logic [31:0]       imm;
    logic [31:0]       base_instr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [7:0]        err_count;

    imm_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(ADDR_W'(BASE))) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .imm       (imm),
        .base_instr(base_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the outputs must show right now.
    bit          m_valid;
    logic [31:0] m_instr;
    bit          m_err;
    int          m_addr;
    logic [31:0] m_imm;
    logic [2:0]  m_src;
    int          m_cnt;
    int          m_errcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Which immediate bit lands at instruction bit p (-1: base_instr passes through).
    function automatic int imm_index(input logic [2:0] s, input int p);
        case (s)
            3'd0: return (p >= 20) ? p - 20 : -1;
            3'd1: begin
                if (p >= 25) return p - 20;
                if (p >= 7 && p <= 11) return p - 7;
                return -1;
            end
            3'd2: begin
                if (p == 31) return 12;
                if (p >= 25) return p - 20;
                if (p >= 8 && p <= 11) return p - 7;
                if (p == 7) return 11;
                return -1;
            end
            3'd3: begin
                if (p == 31) return 20;
                if (p >= 21) return p - 20;
                if (p == 20) return 11;
                if (p >= 12) return p;
                return -1;
            end
            3'd4: return (p >= 12) ? p : -1;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] ref_encode(input logic [2:0] s, input logic [31:0] im,
                                               input logic [31:0] b);
        logic [31:0] r;
        int k;
        r = b;
        if (s <= 3'd4) begin
            for (int p = 0; p < 32; p++) begin
                k = imm_index(s, p);
                if (k >= 0) r[p] = im[k];
            end
        end
        return r;
    endfunction

    function automatic bit ref_err(input logic [2:0] s, input logic [31:0] im);
        int x;
        x = signed'(im);
        case (s)
            3'd0, 3'd1: return !(x >= -2048 && x <= 2047);
            3'd2:       return !(x >= -4096 && x <= 4095 && (x % 2) == 0);
            3'd3:       return !(x >= -1048576 && x <= 1048575 && (x % 2) == 0);
            3'd4:       return (im % 32'd4096) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    // The core's immediate extender.
    function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] s);
        case (s)
            3'd0: return {{20{i[31]}}, i[31:20]};
            3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {i[31:12], 12'h000};
        endcase
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_instr  = '0;
        m_err    = 1'b0;
        m_addr   = BASE;
        m_cnt    = BASE;
        m_errcnt = 0;
    endtask

    task automatic compare_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("err_count", {24'd0, err_count}, 32'(m_errcnt));
        if (m_valid) begin
            chk("out_instr", out_instr, m_instr);
            chk("out_addr", {30'd0, out_addr}, 32'(m_addr));
            chk("out_err", {31'd0, out_err}, {31'd0, m_err});
        end
    endtask

    // One clock: called at a falling edge, drives inputs, advances model, compares.
    task automatic step(input bit v, input logic [2:0] s, input logic [31:0] im,
                        input logic [31:0] b, input bit ordy, input bit c);
        bit acc;
        bit e;
        in_valid   = v;
        imm_src    = s;
        imm        = im;
        base_instr = b;
        out_ready  = ordy;
        clr        = c;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || ordy)});
        if (m_valid && ordy && !m_err)
            chk("roundtrip", extend(out_instr, m_src), m_imm);
        acc = v && (!m_valid || ordy);
        e   = ref_err(s, im);
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_instr = ref_encode(s, im, b);
            m_err   = e;
            m_imm   = im;
            m_src   = s;
            m_addr  = c ? BASE : m_cnt;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (c) begin
            m_cnt    = acc ? ((BASE + 1) & AMASK) : BASE;
            m_errcnt = (acc && e) ? 1 : 0;
        end else if (acc) begin
            m_cnt = (m_cnt + 1) & AMASK;
            if (e && m_errcnt < 255) m_errcnt++;
        end
        @(negedge clk);
        compare_outputs();
    endtask

    function automatic logic [31:0] rand_imm(input logic [2:0] s);
        int x;
        if ($urandom_range(0, 4) == 0) return $urandom();
        case (s)
            3'd0, 3'd1: x = int'($urandom_range(0, 4095)) - 2048;
            3'd2:       x = (int'($urandom_range(0, 8191)) - 4096) & ~1;
            3'd3:       x = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
            default:    x = int'($urandom() & 32'hFFFFF000);
        endcase
        return 32'(x);
    endfunction

    initial begin
        int exp_addr[5];
        int r;
        logic [2:0] s;
        exp_addr = '{0, 1, 2, 3, 0};

        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; imm_src = '0; imm = '0;
        base_instr = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_out_addr", {30'd0, out_addr}, 32'(BASE));
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        reset = 1'b0;

        // Directed encodings with hand-computed results.
        step(1, 3'd0, 32'hFFFFFFFF, 32'h00000013, 1, 0);
        chk("dir_I_instr", out_instr, 32'hFFF00013);
        chk("dir_I_err", {31'd0, out_err}, 32'd0);
        chk("dir_I_addr", {30'd0, out_addr}, 32'd0);
        step(1, 3'd0, 32'h00000800, 32'h00000013, 1, 0);
        chk("dir_I_range_err", {31'd0, out_err}, 32'd1);
        chk("dir_I_errcnt", {24'd0, err_count}, 32'd1);
        step(1, 3'd2, 32'hFFFFFFFC, 32'h00000063, 1, 0);
        chk("dir_B_instr", out_instr, 32'hFE000EE3);
        step(1, 3'd2, 32'h00000003, 32'h00000063, 1, 0);
        chk("dir_B_odd_err", {31'd0, out_err}, 32'd1);
        step(1, 3'd3, 32'h00000800, 32'h000000EF, 1, 0);
        chk("dir_J_instr", out_instr, 32'h001000EF);
        step(1, 3'd4, 32'h12345000, 32'h00000037, 1, 0);
        chk("dir_U_instr", out_instr, 32'h12345037);
        step(1, 3'd4, 32'h12345001, 32'h00000037, 1, 0);
        chk("dir_U_err", {31'd0, out_err}, 32'd1);
        step(1, 3'd6, 32'h00000000, 32'hDEADBEEF, 1, 0);
        chk("dir_bad_src_instr", out_instr, 32'hDEADBEEF);
        chk("dir_bad_src_err", {31'd0, out_err}, 32'd1);

        // Backpressure: second request waits, first word held stable.
        step(0, 3'd0, 0, 0, 1, 1);
        step(1, 3'd0, 32'h5, 32'h00000013, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 3'd1, 32'h10, 32'h00000023, 0, 0);
            chk("bp_hold_instr", out_instr, 32'h00500013);
            chk("bp_hold_addr", {30'd0, out_addr}, 32'd0);
        end
        step(1, 3'd1, 32'h10, 32'h00000023, 1, 0);
        chk("bp_second_instr", out_instr, 32'h00000823);
        chk("bp_second_addr", {30'd0, out_addr}, 32'd1);
        step(0, 3'd0, 0, 0, 1, 0);
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Address wrap, then clr coinciding with an accept.
        step(0, 3'd0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 3'd0, 32'(i), 32'h00000013, 1, 0);
            chk("wrap_addr", {30'd0, out_addr}, 32'(exp_addr[i]));
        end
        step(1, 3'd5, 0, 32'h00000013, 1, 0);
        step(1, 3'd0, 32'h7, 32'h00000013, 1, 1);
        chk("clr_addr", {30'd0, out_addr}, 32'(BASE));
        chk("clr_errcnt", {24'd0, err_count}, 32'd0);
        step(1, 3'd0, 32'h8, 32'h00000013, 1, 0);
        chk("clr_next_addr", {30'd0, out_addr}, 32'(BASE + 1));

        // err_count saturation.
        for (int i = 0; i < 260; i++) step(1, 3'd7, 32'(i), 32'h00000013, 1, 0);
        chk("errcnt_sat", {24'd0, err_count}, 32'd255);

        // Reset while a word is held under backpressure.
        step(1, 3'd0, 32'h1, 32'h00000013, 0, 0);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_errcnt", {24'd0, err_count}, 32'd0);
        chk("rst_mid_addr", {30'd0, out_addr}, 32'(BASE));
        @(negedge clk);
        reset = 1'b0;
        step(1, 3'd0, 32'h2, 32'h00000093, 1, 0);
        chk("rst_mid_first_addr", {30'd0, out_addr}, 32'(BASE));
        chk("rst_mid_first_instr", out_instr, 32'h00200093);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 19));
            s = (r < 17) ? 3'(r % 5) : 3'(r - 12);
            step($urandom_range(0, 3) != 0, s, rand_imm(s), $urandom(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        step(0, 3'd0, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Immediate encoder for the RV32I single-cycle core toolchain path: the inverse of the core's immediate extender. It accepts a 32-bit immediate, an instruction format code and a base instruction word. It packs the immediate into that format's scattered bit positions, range-checks it, and emits the finished instruction word with a sequential instruction-memory address. It sits between the boot/program loader and the instruction-memory write port, behind valid/ready handshakes on both sides.

## Interface
- ADDR_W, 10, width of word address counter
- BASE_ADDR, 0, address given to the first word after reset or clr
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- clr  in  1  synchronous; reloads address counter to BASE_ADDR, clears err_count
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept this cycle
- imm_src  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U (core ImmSrc encoding)
- imm  in  32  immediate value as the core sees it after extension
- base_instr  in  32  opcode/rd/rs1/rs2/funct fields; bits in immediate positions ignored
- out_valid  out  1  out_instr/out_addr/out_err valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address for out_instr
- out_err  out  1  immediate not representable, or illegal imm_src
- err_count  out  8  saturating count of emitted words with out_err=1

## Operation
- Single output register stage. in_ready = !out_valid || out_ready. Accept = in_valid && in_ready.
- On accept, load out_instr, out_err, out_addr=addr_cnt; set out_valid; addr_cnt <= addr_cnt+1 (mod 2^ADDR_W, wraps silently).
- On out_valid && out_ready without a new accept, clear out_valid. Held outputs stay stable while out_valid && !out_ready.
- Packing: immediate positions in base_instr are overwritten; all other bits pass through.
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - U: [31:12]=imm[31:12]
- Range check (err if false):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
- Error handling:
  - On err, packing still uses the truncated bits.
  - imm_src 101–111: out_instr=base_instr unchanged, out_err=1.
- err_count increments on each accept with err=1 and saturates at 255.
- Invariant: for any non-error word, the core's extender applied to out_instr with the same imm_src returns imm exactly.

## Timing
- Latency: 1 cycle from accept to out_valid. Throughput: 1 word/cycle while out_ready=1.
- Reset (async assert) values:
  - out_valid=0, out_instr=0, out_err=0.
  - out_addr=BASE_ADDR, addr_cnt=BASE_ADDR, err_count=0.
  - in_ready=1 in the first cycle after deassertion.
- Reset mid-transfer: held word is discarded and not re-emitted.
- clr has priority over increment:
  - An item accepted in the clr cycle gets out_addr=BASE_ADDR and addr_cnt becomes BASE_ADDR+1.
  - If that item errs, err_count becomes 1.
  - clr does not touch out_valid or the held word.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): new word loaded, out_valid stays 1, no bubble.

## Test plan
- I, base 0x00000013, imm 0xFFFFFFFF -> out_instr 0xFFF00013, out_err 0, out_addr 0; then I, imm 0x00000800 -> out_err 1, err_count 1.
- B, base 0x00000063, imm 0xFFFFFFFC -> out_instr 0xFE000EE3; imm 0x00000002 with imm[0] set (0x3) -> out_err 1.
- J, base 0x000000EF, imm 0x00000800 -> out_instr 0x001000EF; U, base 0x00000037, imm 0x12345000 -> 0x12345037; imm 0x12345001 -> out_err 1.
- Backpressure: two requests back-to-back, out_ready=0 for 3 cycles -> in_ready=0 after first accept, out_instr stable; on release, words emitted in order at addrs 0,1, none lost or duplicated.
- Wrap and clr: ADDR_W=2, five requests -> out_addr 0,1,2,3,0; clr with accept in the same cycle -> out_addr BASE_ADDR, next word BASE_ADDR+1, err_count 0.
- Reset asserted while out_valid=1, out_ready=0 -> out_valid 0 immediately, err_count 0; random round-trip check of 1000 legal immediates through the extender equals input.
